// File: rtl/redund_sel.sv
// redund_sel: N-way redundant channel selector with per-channel link debounce,
// automatic fail-over or manual selection, and switching only at frame boundaries
// followed by a FIFO reset gap.
// Optional feature: define REDUND_SEL_REVERT_EN to compile in the wait-to-restore
// timer and honour `revertive`; otherwise selection is purely non-revertive.
module redund_sel #(
    parameter int NUM_CH         = 2,
    parameter int SEL_W          = 1,
    parameter int PRIMARY        = 0,
    parameter int HOLDOFF_CYCLES = 1250000,
    parameter int WTR_CYCLES     = 125000000,
    parameter int GAP_CYCLES     = 12,
    parameter int DRAIN_MAX      = 1250
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] link,
    input  logic              mode_auto,
    input  logic              revertive,
    input  logic [SEL_W-1:0]  manual_sel,
    input  logic              up_tx_en,
    output logic [SEL_W-1:0]  sel,
    output logic [NUM_CH-1:0] sel_onehot,
    output logic [NUM_CH-1:0] fifo_rst,
    output logic              switch_pulse,
    output logic              no_link,
    output logic              forced
);
    localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam int DW = $clog2(DRAIN_MAX + 1);

    typedef enum logic [1:0] {ACTIVE, DRAIN, GAP} state_t;

    state_t            r_state;
    logic [NUM_CH-1:0] r_dlink;
    logic [HW-1:0]     r_hcnt [NUM_CH];
    logic              r_no_link;
    logic [SEL_W-1:0]  r_sel;
    logic [NUM_CH-1:0] r_onehot;
    logic [NUM_CH-1:0] r_fifo_rst;
    logic              r_pulse;
    logic              r_forced;
    logic              r_idle;
    logic [DW-1:0]     r_dcnt;
    logic [GW-1:0]     r_gcnt;

    logic [NUM_CH-1:0] w_dlink_nxt;
    logic              w_any;
    logic              w_cur_ok;
    logic              w_better;
    logic [SEL_W-1:0]  w_best;
    logic              w_revert;
    logic [SEL_W-1:0]  w_target;
    logic              w_idle_exit;

    // Debounced link toggles once the raw value has disagreed for HOLDOFF_CYCLES cycles
    always_comb begin
        for (int i = 0; i < NUM_CH; i++)
            w_dlink_nxt[i] = r_dlink[i] ^ (link[i] != r_dlink[i] && r_hcnt[i] == HW'(HOLDOFF_CYCLES - 1));
    end

    // Per-channel holdoff counters, debounced link state and registered no-link flag
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++)
            r_hcnt[i] <= (rst || link[i] == r_dlink[i] || r_hcnt[i] == HW'(HOLDOFF_CYCLES - 1)) ? '0 : r_hcnt[i] + 1'b1;
        r_dlink   <= rst ? '0 : w_dlink_nxt;
        r_no_link <= rst ? 1'b1 : ~|w_dlink_nxt;
    end

    // Walk channels in priority order: best healthy one, current health, and whether a better one is up
    always_comb begin
        w_any    = 1'b0;
        w_cur_ok = 1'b0;
        w_better = 1'b0;
        w_best   = SEL_W'(PRIMARY);
        for (int k = 0; k < NUM_CH; k++) begin
            if (r_sel == SEL_W'((PRIMARY + k) % NUM_CH)) begin
                w_cur_ok = r_dlink[(PRIMARY + k) % NUM_CH];
                w_better = w_any;
            end
            if (!w_any && r_dlink[(PRIMARY + k) % NUM_CH]) begin
                w_any  = 1'b1;
                w_best = SEL_W'((PRIMARY + k) % NUM_CH);
            end
        end
    end

`ifdef REDUND_SEL_REVERT_EN
    localparam int WW = $clog2(WTR_CYCLES + 1);
    logic [WW-1:0] r_wtr;
    logic          w_wtr_run;
    assign w_wtr_run = mode_auto && revertive && w_cur_ok && w_better;
    assign w_revert  = w_wtr_run && r_wtr == WW'(WTR_CYCLES);
    // Wait-to-restore timer: counts while a better channel is healthy, holds at WTR_CYCLES
    always_ff @(posedge clk) begin
        r_wtr <= (rst || !w_wtr_run) ? '0 : w_revert ? r_wtr : r_wtr + 1'b1;
    end
`else
    assign w_revert = revertive & w_better & 1'b0;
`endif

    assign w_target = !mode_auto ? ((32'(manual_sel) < NUM_CH) ? manual_sel : r_sel)
                    : ((w_any && !w_cur_ok) || w_revert) ? w_best : r_sel;

    assign w_idle_exit = r_idle && !up_tx_en;

    // Switch sequencer: wait for a frame boundary (or timeout), then hold all FIFOs in reset
    always_ff @(posedge clk) begin
        r_pulse <= 1'b0;
        if (rst) begin
            r_state    <= ACTIVE;
            r_sel      <= SEL_W'(PRIMARY);
            r_onehot   <= NUM_CH'(1) << PRIMARY;
            r_fifo_rst <= ~(NUM_CH'(1) << PRIMARY);
            r_forced   <= 1'b0;
            r_idle     <= 1'b0;
            r_dcnt     <= '0;
            r_gcnt     <= '0;
        end else begin
            case (r_state)
                ACTIVE: begin
                    r_idle <= 1'b0;
                    r_dcnt <= '0;
                    if (w_target != r_sel) r_state <= DRAIN;
                end
                DRAIN: begin
                    r_idle <= ~up_tx_en;
                    r_dcnt <= r_dcnt + 1'b1;
                    if (w_target == r_sel) begin
                        r_state <= ACTIVE;
                    end else if (w_idle_exit || r_dcnt == DW'(DRAIN_MAX - 1)) begin
                        r_state    <= GAP;
                        r_sel      <= w_target;
                        r_onehot   <= NUM_CH'(1) << w_target;
                        r_fifo_rst <= '1;
                        r_pulse    <= 1'b1;
                        r_forced   <= !w_idle_exit;
                        r_gcnt     <= '0;
                    end
                end
                default: begin
                    r_gcnt <= r_gcnt + 1'b1;
                    if (r_gcnt == GW'(GAP_CYCLES - 1)) begin
                        r_state    <= ACTIVE;
                        r_fifo_rst <= ~r_onehot;
                    end
                end
            endcase
        end
    end

    assign sel          = r_sel;
    assign sel_onehot   = r_onehot;
    assign fifo_rst     = r_fifo_rst;
    assign switch_pulse = r_pulse;
    assign no_link      = r_no_link;
    assign forced       = r_forced;
endmodule

// File: tb/tb_redund_sel.sv
// tb_redund_sel: table-driven vectors plus directed multi-cycle sequences for redund_sel
module tb_redund_sel;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] link = '0;
    logic       mode_auto = 1'b1;
    logic       revertive = 1'b0;
    logic [1:0] manual_sel = '0;
    logic       up_tx_en = 1'b0;
    logic [1:0] sel;
    logic [2:0] sel_onehot;
    logic [2:0] fifo_rst;
    logic       switch_pulse;
    logic       no_link;
    logic       forced;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic       rst;
        logic [2:0] link;
        logic       mode_auto;
        logic       revertive;
        logic [1:0] manual_sel;
        logic       up_tx_en;
        int         n;
        logic [1:0] sel;
        logic [2:0] onehot;
        logic [2:0] fifo_rst;
        logic       pulse;
        logic       no_link;
        logic       forced;
    } vec_t;

    vec_t vq[$];

    redund_sel #(
        .NUM_CH(3), .SEL_W(2), .PRIMARY(0), .HOLDOFF_CYCLES(4),
        .WTR_CYCLES(8), .GAP_CYCLES(3), .DRAIN_MAX(16)
    ) dut (
        .clk(clk), .rst(rst), .link(link), .mode_auto(mode_auto),
        .revertive(revertive), .manual_sel(manual_sel), .up_tx_en(up_tx_en),
        .sel(sel), .sel_onehot(sel_onehot), .fifo_rst(fifo_rst),
        .switch_pulse(switch_pulse), .no_link(no_link), .forced(forced)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic add(input logic r, input logic [2:0] l, input logic a, input logic rv,
                       input logic [1:0] ms, input logic tx, input int n,
                       input logic [1:0] s, input logic [2:0] oh, input logic [2:0] fr,
                       input logic p, input logic nl, input logic f);
        vec_t v;
        v = '{r, l, a, rv, ms, tx, n, s, oh, fr, p, nl, f};
        vq.push_back(v);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int chg;
        int pulses;
        //   rst link   au rv ms tx  n  sel oh      fifo    p  nl f
        add(1, 3'b000, 1, 0, 0, 0, 2, 0, 3'b001, 3'b110, 0, 1, 0);
        add(0, 3'b111, 1, 0, 0, 0, 3, 0, 3'b001, 3'b110, 0, 1, 0);
        add(0, 3'b111, 1, 0, 0, 0, 1, 0, 3'b001, 3'b110, 0, 0, 0);
        add(0, 3'b110, 1, 0, 0, 0, 3, 0, 3'b001, 3'b110, 0, 0, 0);
        add(0, 3'b111, 1, 0, 0, 0, 1, 0, 3'b001, 3'b110, 0, 0, 0);
        add(0, 3'b111, 1, 0, 0, 0, 5, 0, 3'b001, 3'b110, 0, 0, 0);
        add(0, 3'b110, 1, 0, 0, 0, 4, 0, 3'b001, 3'b110, 0, 0, 0);
        add(0, 3'b110, 1, 0, 0, 0, 1, 0, 3'b001, 3'b110, 0, 0, 0);
        add(0, 3'b110, 1, 0, 0, 0, 1, 0, 3'b001, 3'b110, 0, 0, 0);
        add(0, 3'b110, 1, 0, 0, 0, 1, 1, 3'b010, 3'b111, 1, 0, 0);
        add(0, 3'b110, 1, 0, 0, 0, 1, 1, 3'b010, 3'b111, 0, 0, 0);
        add(0, 3'b110, 1, 0, 0, 0, 1, 1, 3'b010, 3'b111, 0, 0, 0);
        add(0, 3'b110, 1, 0, 0, 0, 1, 1, 3'b010, 3'b101, 0, 0, 0);
        add(0, 3'b111, 1, 1, 0, 0, 12, 1, 3'b010, 3'b101, 0, 0, 0);
        add(0, 3'b111, 1, 1, 0, 0, 1, 1, 3'b010, 3'b101, 0, 0, 0);
`ifdef REDUND_SEL_REVERT_EN
        add(0, 3'b111, 1, 1, 0, 0, 2, 0, 3'b001, 3'b111, 1, 0, 0);
        add(0, 3'b111, 1, 1, 0, 0, 3, 0, 3'b001, 3'b110, 0, 0, 0);
`else
        add(0, 3'b111, 1, 1, 0, 0, 2, 1, 3'b010, 3'b101, 0, 0, 0);
        add(0, 3'b111, 1, 1, 0, 0, 3, 1, 3'b010, 3'b101, 0, 0, 0);
`endif
        add(0, 3'b110, 1, 0, 0, 0, 12, 1, 3'b010, 3'b101, 0, 0, 0);
        add(0, 3'b111, 1, 0, 0, 0, 30, 1, 3'b010, 3'b101, 0, 0, 0);
        add(0, 3'b111, 0, 0, 2, 0, 3, 2, 3'b100, 3'b111, 1, 0, 0);
        add(0, 3'b111, 0, 0, 2, 0, 3, 2, 3'b100, 3'b011, 0, 0, 0);
        add(0, 3'b111, 0, 0, 3, 0, 10, 2, 3'b100, 3'b011, 0, 0, 0);

        foreach (vq[i]) begin
            rst = vq[i].rst;
            link = vq[i].link;
            mode_auto = vq[i].mode_auto;
            revertive = vq[i].revertive;
            manual_sel = vq[i].manual_sel;
            up_tx_en = vq[i].up_tx_en;
            tick(vq[i].n);
            chk($sformatf("v%0d.sel", i), int'(sel), int'(vq[i].sel));
            chk($sformatf("v%0d.onehot", i), int'(sel_onehot), int'(vq[i].onehot));
            chk($sformatf("v%0d.fifo_rst", i), int'(fifo_rst), int'(vq[i].fifo_rst));
            chk($sformatf("v%0d.pulse", i), int'(switch_pulse), int'(vq[i].pulse));
            chk($sformatf("v%0d.no_link", i), int'(no_link), int'(vq[i].no_link));
            chk($sformatf("v%0d.forced", i), int'(forced), int'(vq[i].forced));
        end

        // Frame boundary: busy for 10 cycles, switch lands 2 idle cycles later
        manual_sel = 2'd1;
        up_tx_en = 1'b1;
        chg = 0;
        pulses = 0;
        for (int c = 1; c <= 14; c++) begin
            if (c == 11) up_tx_en = 1'b0;
            tick(1);
            if (switch_pulse) pulses++;
            if (chg == 0 && sel == 2'd1) chg = c;
        end
        chk("boundary.switch_cycle", chg, 12);
        chk("boundary.pulses", pulses, 1);
        chk("boundary.forced", int'(forced), 0);
        tick(5);
        chk("boundary.fifo_rst", int'(fifo_rst), 3'b101);

        // Busy beyond DRAIN_MAX: forced switch after 16 cycles in DRAIN
        manual_sel = 2'd0;
        up_tx_en = 1'b1;
        chg = 0;
        pulses = 0;
        for (int c = 1; c <= 22; c++) begin
            if (c == 21) up_tx_en = 1'b0;
            tick(1);
            if (switch_pulse) pulses++;
            if (chg == 0 && sel == 2'd0) chg = c;
        end
        chk("forced.switch_cycle", chg, 17);
        chk("forced.pulses", pulses, 1);
        chk("forced.flag", int'(forced), 1);
        chk("forced.fifo_rst", int'(fifo_rst), 3'b110);

        // Next clean switch clears the sticky forced flag
        manual_sel = 2'd1;
        tick(3);
        chk("clean.sel", int'(sel), 1);
        chk("clean.forced", int'(forced), 0);
        tick(3);
        chk("clean.fifo_rst", int'(fifo_rst), 3'b101);

        // Reset in the middle of a GAP abandons the switch
        manual_sel = 2'd2;
        tick(4);
        chk("midgap.fifo_rst", int'(fifo_rst), 3'b111);
        chk("midgap.sel", int'(sel), 2);
        rst = 1'b1;
        tick(1);
        chk("rst.sel", int'(sel), 0);
        chk("rst.onehot", int'(sel_onehot), 3'b001);
        chk("rst.fifo_rst", int'(fifo_rst), 3'b110);
        chk("rst.pulse", int'(switch_pulse), 0);
        chk("rst.no_link", int'(no_link), 1);
        rst = 1'b0;
        mode_auto = 1'b1;
        manual_sel = 2'd0;
        tick(6);
        chk("post.sel", int'(sel), 0);
        chk("post.fifo_rst", int'(fifo_rst), 3'b110);
        chk("post.no_link", int'(no_link), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
